// File: rtl/alu_serial.sv
// Digit-serial ALU: processes DIGIT bits of the operands per clock, LSB digit first,
// and presents result and status flags behind a valid/ready handshake.
module alu_serial #(
   parameter int WIDTH = 64,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             carry_out
);

   localparam int BEATS = WIDTH / DIGIT;
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   localparam logic [2:0] OP_PASS = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t state;
   state_t stateNext;

   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [2:0]       opCode;
   logic             carry;
   logic [CW-1:0]    beat;

   logic [DIGIT-1:0] aDigit;
   logic [DIGIT-1:0] bDigit;
   logic [DIGIT-1:0] digitOut;
   logic [DIGIT:0]   digitSum;
   logic             carryIntoMsb;
   logic             lastBeat;
   logic             isArith;
   logic [WIDTH-1:0] resultShifted;

   // Operands shift right each beat, so the active digit always sits at the bottom.
   always_comb begin
      aDigit       = opA[DIGIT-1:0];
      bDigit       = opB[DIGIT-1:0];
      digitSum     = {1'b0, aDigit} + {1'b0, bDigit} + {{DIGIT{1'b0}}, carry};
      carryIntoMsb = aDigit[DIGIT-1] ^ bDigit[DIGIT-1] ^ digitSum[DIGIT-1];
      lastBeat     = (beat == LAST);
      isArith      = (opCode == OP_ADD) || (opCode == OP_SUB);
      case (opCode)
         OP_PASS:        digitOut = bDigit;
         OP_ADD, OP_SUB: digitOut = digitSum[DIGIT-1:0];
         OP_AND:         digitOut = aDigit & bDigit;
         OP_OR:          digitOut = aDigit | bDigit;
         OP_XOR:         digitOut = aDigit ^ bDigit;
         default:        digitOut = '0;
      endcase
   end

   // New digits enter at the top of the result; after BEATS shifts digit 0 lands at the LSB.
   generate
      if (DIGIT == WIDTH) begin : gFull
         assign resultShifted = digitOut;
      end else begin : gSlice
         assign resultShifted = {digitOut, result[WIDTH-1:DIGIT]};
      end
   endgenerate

   // Next-state and handshake outputs.
   always_comb begin
      stateNext = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) stateNext = RUN;
         end
         RUN: begin
            if (lastBeat) stateNext = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1: B is inverted on capture and the carry preset to 1.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         opA       <= '0;
         opB       <= '0;
         opCode    <= '0;
         carry     <= 1'b0;
         beat      <= '0;
         result    <= '0;
         zero      <= 1'b0;
         negative  <= 1'b0;
         overflow  <= 1'b0;
         carry_out <= 1'b0;
      end else begin
         state <= stateNext;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  opA       <= a;
                  opB       <= (control == OP_SUB) ? ~b : b;
                  opCode    <= control;
                  carry     <= (control == OP_SUB);
                  beat      <= '0;
                  result    <= '0;
                  zero      <= 1'b0;
                  negative  <= 1'b0;
                  overflow  <= 1'b0;
                  carry_out <= 1'b0;
               end
            end
            RUN: begin
               opA    <= opA >> DIGIT;
               opB    <= opB >> DIGIT;
               carry  <= digitSum[DIGIT];
               beat   <= beat + CW'(1);
               result <= resultShifted;
               if (lastBeat) begin
                  zero      <= (resultShifted == '0);
                  negative  <= resultShifted[WIDTH-1];
                  overflow  <= isArith & (carryIntoMsb ^ digitSum[DIGIT]);
                  carry_out <= isArith & digitSum[DIGIT];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: four instances (8/2, 64/4, 64/1, 64/64) share one stimulus
// stream and are checked against hand vectors and a full-width reference model.
module tb_alu_serial;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] a;
   logic [63:0] b;
   logic [2:0]  control;

   logic [3:0]  rdy, ov, zf, nf, vf, cf;
   logic [7:0]  res0;
   logic [63:0] res1, res2, res3;
   logic [63:0] res [4];

   int nVec = 0;
   int nMiss = 0;
   int lat [4];

   typedef struct {
      logic [2:0]  ctl;
      logic [63:0] a;
      logic [63:0] b;
      int          inst;
      logic [63:0] expRes;
      logic [3:0]  expFlags;
   } vec_t;

   vec_t vecs [14];

   always #5 clk = ~clk;

   assign res[0] = {56'd0, res0};
   assign res[1] = res1;
   assign res[2] = res2;
   assign res[3] = res3;

   alu_serial #(.WIDTH(8), .DIGIT(2)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]),
      .a(a[7:0]), .b(b[7:0]), .control(control), .out_valid(ov[0]),
      .out_ready(out_ready), .result(res0), .zero(zf[0]), .negative(nf[0]),
      .overflow(vf[0]), .carry_out(cf[0]));

   alu_serial #(.WIDTH(64), .DIGIT(4)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]),
      .a(a), .b(b), .control(control), .out_valid(ov[1]),
      .out_ready(out_ready), .result(res1), .zero(zf[1]), .negative(nf[1]),
      .overflow(vf[1]), .carry_out(cf[1]));

   alu_serial #(.WIDTH(64), .DIGIT(1)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]),
      .a(a), .b(b), .control(control), .out_valid(ov[2]),
      .out_ready(out_ready), .result(res2), .zero(zf[2]), .negative(nf[2]),
      .overflow(vf[2]), .carry_out(cf[2]));

   alu_serial #(.WIDTH(64), .DIGIT(64)) dut3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy[3]),
      .a(a), .b(b), .control(control), .out_valid(ov[3]),
      .out_ready(out_ready), .result(res3), .zero(zf[3]), .negative(nf[3]),
      .overflow(vf[3]), .carry_out(cf[3]));

   function automatic int widthOf(input int i);
      return (i == 0) ? 8 : 64;
   endfunction

   function automatic int beatsOf(input int i);
      case (i)
         0:       return 4;
         1:       return 16;
         2:       return 64;
         default: return 1;
      endcase
   endfunction

   // Full-width reference: plain wide arithmetic, flags derived from operand/result signs.
   function automatic void modelOp(input int w, input logic [2:0] ctl,
                                   input logic [63:0] av, input logic [63:0] bv,
                                   output logic [63:0] r, output logic z, output logic n,
                                   output logic v, output logic c);
      logic [63:0] mask;
      logic [64:0] s;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      av = av & mask;
      bv = bv & mask;
      v = 1'b0;
      c = 1'b0;
      case (ctl)
         3'b000: r = bv;
         3'b010: begin
            s = {1'b0, av} + {1'b0, bv};
            r = s[63:0] & mask;
            c = s[w];
            v = (av[w-1] == bv[w-1]) && (r[w-1] != av[w-1]);
         end
         3'b011: begin
            r = (av - bv) & mask;
            c = (av >= bv);
            v = (av[w-1] != bv[w-1]) && (r[w-1] != av[w-1]);
         end
         3'b100: r = av & bv;
         3'b101: r = av | bv;
         3'b110: r = av ^ bv;
         default: r = '0;
      endcase
      z = (r == 64'd0);
      n = r[w-1];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nMiss++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic checkModel(input string tag, input logic [2:0] ctl,
                             input logic [63:0] av, input logic [63:0] bv);
      logic [63:0] r;
      logic z, n, v, c;
      for (int i = 0; i < 4; i++) begin
         modelOp(widthOf(i), ctl, av, bv, r, z, n, v, c);
         checkOutput($sformatf("%s dut%0d result", tag, i), res[i], r);
         checkOutput($sformatf("%s dut%0d flags zncv", tag, i),
                     {60'd0, zf[i], nf[i], vf[i], cf[i]}, {60'd0, z, n, v, c});
      end
   endtask

   // Accept one op on all instances, scramble inputs, wait for every out_valid, check
   // latency and model results; outputs are left held in DONE.
   task automatic applyStimulus(input string tag, input logic [2:0] ctl,
                                input logic [63:0] av, input logic [63:0] bv);
      @(negedge clk);
      a = av; b = bv; control = ctl; in_valid = 1'b1; out_ready = 1'b0;
      checkOutput({tag, " in_ready before accept"}, {60'd0, rdy}, 64'hF);
      @(posedge clk);
      #1;
      in_valid = 1'b0; a = ~av; b = bv ^ 64'h5A5A_0000_FFFF_1234; control = 3'b111;
      for (int i = 0; i < 4; i++) lat[i] = -1;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 4; i++) if (lat[i] < 0 && ov[i]) lat[i] = cyc;
         if (ov == 4'hF) break;
      end
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("%s dut%0d latency", tag, i), 64'(lat[i]), 64'(beatsOf(i)));
      checkModel(tag, ctl, av, bv);
   endtask

   task automatic releaseOutput(input string tag);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, " in_ready after handshake"}, {60'd0, rdy}, 64'hF);
      checkOutput({tag, " out_valid after handshake"}, {60'd0, ov}, 64'h0);
   endtask

   task automatic checkCleared(input string tag);
      checkOutput({tag, " in_ready"}, {60'd0, rdy}, 64'hF);
      checkOutput({tag, " out_valid"}, {60'd0, ov}, 64'h0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("%s dut%0d result", tag, i), res[i], 64'd0);
         checkOutput($sformatf("%s dut%0d flags", tag, i),
                     {60'd0, zf[i], nf[i], vf[i], cf[i]}, 64'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int acc [4][2];
      int accCnt [4];
      logic [63:0] ra, rb;
      logic [2:0] rc;
      bit drained;

      // Flags order in the table: {zero, negative, overflow, carry_out}.
      vecs[0]  = '{3'b010, 64'h7F, 64'h01, 0, 64'h80, 4'b0110};
      vecs[1]  = '{3'b011, 64'h05, 64'h05, 0, 64'h00, 4'b1001};
      vecs[2]  = '{3'b011, 64'h00, 64'h01, 0, 64'hFF, 4'b0100};
      vecs[3]  = '{3'b010, 64'hFF, 64'hFF, 0, 64'hFE, 4'b0101};
      vecs[4]  = '{3'b100, 64'hF0F0F0F0F0F0F0F0, 64'hFF00000000000000, 1, 64'hF000000000000000, 4'b0100};
      vecs[5]  = '{3'b101, 64'hF0F0F0F0F0F0F0F0, 64'hFF00000000000000, 1, 64'hFFF0F0F0F0F0F0F0, 4'b0100};
      vecs[6]  = '{3'b110, 64'hF0F0F0F0F0F0F0F0, 64'hFF00000000000000, 1, 64'h0FF0F0F0F0F0F0F0, 4'b0000};
      vecs[7]  = '{3'b000, 64'hF0F0F0F0F0F0F0F0, 64'hFF00000000000000, 1, 64'hFF00000000000000, 4'b0100};
      vecs[8]  = '{3'b111, 64'hF0F0F0F0F0F0F0F0, 64'hFF00000000000000, 1, 64'h0, 4'b1000};
      vecs[9]  = '{3'b001, 64'hF0F0F0F0F0F0F0F0, 64'hFF00000000000000, 1, 64'h0, 4'b1000};
      vecs[10] = '{3'b010, 64'hFFFFFFFFFFFFFFFF, 64'h1, 2, 64'h0, 4'b1001};
      vecs[11] = '{3'b011, 64'h8000000000000000, 64'h1, 3, 64'h7FFFFFFFFFFFFFFF, 4'b0011};
      vecs[12] = '{3'b010, 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 3, 64'hFFFFFFFFFFFFFFFE, 4'b0110};
      vecs[13] = '{3'b011, 64'h3, 64'hA, 1, 64'hFFFFFFFFFFFFFFF9, 4'b0100};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; control = '0;
      repeat (2) @(posedge clk);
      #1;
      checkCleared("reset");
      @(negedge clk);
      reset = 1'b0;

      for (int k = 0; k < 14; k++) begin
         applyStimulus($sformatf("vec%0d", k), vecs[k].ctl, vecs[k].a, vecs[k].b);
         checkOutput($sformatf("vec%0d hand result", k), res[vecs[k].inst], vecs[k].expRes);
         checkOutput($sformatf("vec%0d hand flags", k),
                     {60'd0, zf[vecs[k].inst], nf[vecs[k].inst], vf[vecs[k].inst], cf[vecs[k].inst]},
                     {60'd0, vecs[k].expFlags});
         releaseOutput($sformatf("vec%0d", k));
      end

      // Held in DONE while inputs toggle; handshake edge must not also accept.
      applyStimulus("stall", 3'b010, 64'h0123456789ABCDEF, 64'h1111111111111111);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         a = {$urandom, $urandom}; b = {$urandom, $urandom}; in_valid = k[0];
         @(posedge clk);
         #1;
         checkOutput($sformatf("stall%0d in_ready", k), {60'd0, rdy}, 64'h0);
         checkOutput($sformatf("stall%0d out_valid", k), {60'd0, ov}, 64'hF);
         checkModel($sformatf("stall%0d", k), 3'b010, 64'h0123456789ABCDEF, 64'h1111111111111111);
      end
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0; out_ready = 1'b0;
      checkOutput("stall release in_ready", {60'd0, rdy}, 64'hF);
      checkOutput("stall release out_valid", {60'd0, ov}, 64'h0);

      // Reset two beats into RUN aborts the op.
      @(negedge clk);
      a = 64'hA5A5A5A5A5A5A5A5; b = 64'h5A5A5A5A5A5A5A5A; control = 3'b010; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkCleared("abort");
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("abort idle%0d out_valid", k), {60'd0, ov}, 64'h0);
      end
      applyStimulus("postabort", 3'b010, 64'h12, 64'h34);
      checkOutput("postabort hand result", res[0], 64'h46);
      releaseOutput("postabort");

      // Back-to-back throughput with in_valid and out_ready held high.
      @(negedge clk);
      a = 64'h0F; b = 64'h01; control = 3'b010; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) accCnt[i] = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         for (int i = 0; i < 4; i++)
            if (rdy[i] && accCnt[i] < 2) begin
               acc[i][accCnt[i]] = cyc;
               accCnt[i]++;
            end
         @(negedge clk);
      end
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) continue;
         checkOutput($sformatf("throughput dut%0d accepts", i), 64'(accCnt[i]), 64'd2);
         if (accCnt[i] == 2)
            checkOutput($sformatf("throughput dut%0d interval", i),
                        64'(acc[i][1] - acc[i][0]), 64'(beatsOf(i) + 2));
      end
      drained = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         if (rdy == 4'hF) begin
            drained = 1'b1;
            break;
         end
      end
      out_ready = 1'b0;
      checkOutput("drain completed", {63'd0, drained}, 64'd1);

      for (int k = 0; k < 12; k++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         rc = 3'($urandom_range(0, 7));
         if (k == 0) rb = ra;
         if (k == 1) begin ra = 64'h8000000000000000; rb = 64'h8000000000000000; rc = 3'b010; end
         applyStimulus($sformatf("rand%0d", k), rc, ra, rb);
         releaseOutput($sformatf("rand%0d", k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
